// File: rtl/stage_mem.sv
// Memory pipeline stage: issues one load/store at a time to a handshaked memory port,
// stalls upstream while the access is outstanding, and bounds the wait with a timeout.
module stage_mem #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_b,
  input  logic [1:0]  wbi,
  input  logic        M,
  input  logic [3:0]  regaddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [1:0]  wbi_o,
  output logic [3:0]  regaddr_o,
  output logic        mem_error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Wait count value seen in the MAX_WAIT-th BUSY cycle without an ack.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e      state_r,       state_nxt_s;
  logic [7:0]  wait_cnt_r,    wait_cnt_nxt_s;
  logic        mem_req_r,     mem_req_nxt_s;
  logic        mem_we_r,      mem_we_nxt_s;
  logic [31:0] mem_addr_r,    mem_addr_nxt_s;
  logic [31:0] mem_wdata_r,   mem_wdata_nxt_s;
  logic [31:0] wb_data_r,     wb_data_nxt_s;
  logic [1:0]  wbi_o_r,       wbi_o_nxt_s;
  logic [3:0]  regaddr_o_r,   regaddr_o_nxt_s;
  logic        mem_error_r,   mem_error_nxt_s;
  logic [1:0]  hold_wbi_r,    hold_wbi_nxt_s;
  logic [3:0]  hold_reg_r,    hold_reg_nxt_s;
  logic        stall_s;

  logic        mem_op_s;
  logic        aligned_s;
  logic [1:0]  issue_wbi_s;
  logic        last_wait_s;

  assign mem_op_s    = M | wbi[1];
  assign aligned_s   = (alu_out[1:0] == 2'b00);
  // A store never writes a register, even if the load bit is also set.
  assign issue_wbi_s = M ? 2'b00 : wbi;
  assign last_wait_s = (wait_cnt_r == LAST_WAIT);

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_nxt_s     = state_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    wb_data_nxt_s   = 32'h0000_0000;
    wbi_o_nxt_s     = 2'b00;
    regaddr_o_nxt_s = 4'h0;
    mem_error_nxt_s = mem_error_r;
    hold_wbi_nxt_s  = hold_wbi_r;
    hold_reg_nxt_s  = hold_reg_r;
    stall_s         = 1'b0;

    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          if (aligned_s) begin
            stall_s         = 1'b1;
            state_nxt_s     = BUSY;
            wait_cnt_nxt_s  = 8'd0;
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = M;
            mem_addr_nxt_s  = alu_out;
            mem_wdata_nxt_s = data_b;
            hold_wbi_nxt_s  = issue_wbi_s;
            hold_reg_nxt_s  = regaddr;
          end else begin
            mem_error_nxt_s = 1'b1;
          end
        end else begin
          wb_data_nxt_s   = alu_out;
          wbi_o_nxt_s     = wbi;
          regaddr_o_nxt_s = regaddr;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_nxt_s     = IDLE;
          mem_req_nxt_s   = 1'b0;
          mem_we_nxt_s    = 1'b0;
          wb_data_nxt_s   = mem_we_r ? mem_addr_r : mem_rdata;
          wbi_o_nxt_s     = hold_wbi_r;
          regaddr_o_nxt_s = hold_reg_r;
        end else if (last_wait_s) begin
          state_nxt_s     = IDLE;
          mem_req_nxt_s   = 1'b0;
          mem_we_nxt_s    = 1'b0;
          mem_error_nxt_s = 1'b1;
        end else begin
          stall_s        = 1'b1;
          wait_cnt_nxt_s = (wait_cnt_r == 8'hFF) ? wait_cnt_r : (wait_cnt_r + 8'd1);
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        mem_req_nxt_s = 1'b0;
        mem_we_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 8'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      wb_data_r   <= 32'h0000_0000;
      wbi_o_r     <= 2'b00;
      regaddr_o_r <= 4'h0;
      mem_error_r <= 1'b0;
      hold_wbi_r  <= 2'b00;
      hold_reg_r  <= 4'h0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      wb_data_r   <= wb_data_nxt_s;
      wbi_o_r     <= wbi_o_nxt_s;
      regaddr_o_r <= regaddr_o_nxt_s;
      mem_error_r <= mem_error_nxt_s;
      hold_wbi_r  <= hold_wbi_nxt_s;
      hold_reg_r  <= hold_reg_nxt_s;
    end
  end

  // Stall is gated by reset so upstream is never held while the stage is cleared.
  assign stall     = stall_s & reset;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign wb_data   = wb_data_r;
  assign wbi_o     = wbi_o_r;
  assign regaddr_o = regaddr_o_r;
  assign mem_error = mem_error_r;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_stage_mem;

  localparam int MW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_out, data_b, mem_rdata;
  logic [1:0]  wbi;
  logic        M, mem_ack;
  logic [3:0]  regaddr;
  logic        mem_req, mem_we, stall, mem_error;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [1:0]  wbi_o;
  logic [3:0]  regaddr_o;

  int n_checks = 0;
  int n_pass   = 0;

  stage_mem #(.MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .alu_out(alu_out), .data_b(data_b), .wbi(wbi),
    .M(M), .regaddr(regaddr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .wb_data(wb_data), .wbi_o(wbi_o), .regaddr_o(regaddr_o),
    .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: one outstanding access at a time, described by what it still owes.
  bit          m_busy;
  int          m_waited;
  bit          m_store;
  logic [31:0] m_addr;
  logic [1:0]  m_wbi;
  logic [3:0]  m_reg;
  logic        e_req, e_we, e_err, e_stall;
  logic [31:0] e_addr, e_wdata, e_wb;
  logic [1:0]  e_wbi;
  logic [3:0]  e_reg;
  bit          e_wb_chk, e_reg_chk;

  initial begin
    m_busy = 0; m_waited = 0; m_store = 0; m_addr = '0; m_wbi = '0; m_reg = '0;
    e_req = 0; e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_wb = '0;
    e_wbi = '0; e_reg = '0; e_wb_chk = 1; e_reg_chk = 1;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_busy = 0; m_waited = 0;
        e_req = 0; e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_wb = '0;
        e_wbi = '0; e_reg = '0; e_wb_chk = 1; e_reg_chk = 1;
      end
      if (!reset) e_stall = 1'b0;
      else if (!m_busy) e_stall = (M | wbi[1]) && (alu_out[1:0] == 2'b00);
      else e_stall = !mem_ack && (m_waited + 1 < MW);
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("mem_error", {31'b0, mem_error}, {31'b0, e_err});
      chk("wbi_o", {30'b0, wbi_o}, {30'b0, e_wbi});
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_wb_chk) chk("wb_data", wb_data, e_wb);
      if (e_reg_chk) chk("regaddr_o", {28'b0, regaddr_o}, {28'b0, e_reg});
      if (reset) begin
        // Default next outcome is a bubble with don't-care data.
        e_wbi = 2'b00; e_wb_chk = 0; e_reg_chk = 0;
        if (m_busy) begin
          if (mem_ack) begin
            m_busy = 0; e_req = 0; e_we = 0;
            e_wb = m_store ? m_addr : mem_rdata; e_wbi = m_wbi; e_reg = m_reg;
            e_wb_chk = 1; e_reg_chk = 1;
          end else if (m_waited + 1 >= MW) begin
            m_busy = 0; e_req = 0; e_we = 0; e_err = 1; e_wb = '0; e_wb_chk = 1;
          end else begin
            m_waited++;
          end
        end else if (M | wbi[1]) begin
          if (alu_out[1:0] == 2'b00) begin
            m_busy = 1; m_waited = 0; m_store = M; m_addr = alu_out;
            m_wbi = M ? 2'b00 : wbi; m_reg = regaddr;
            e_req = 1; e_we = M; e_addr = alu_out; e_wdata = data_b;
          end else begin
            e_err = 1;
          end
        end else begin
          e_wb = alu_out; e_wbi = wbi; e_reg = regaddr; e_wb_chk = 1; e_reg_chk = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic m, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] r);
    M = m; wbi = w; alu_out = a; data_b = d; regaddr = r;
  endtask

  // Runs the presented instruction to retirement; ack pulses in BUSY cycle ack_at (0 = never).
  task automatic run_mem(input int ack_at, input logic [31:0] rdata, output int stall_n,
                         output int req_n, output logic [31:0] addr_seen,
                         output logic [31:0] wdata_seen, output logic we_seen);
    bit done = 0;
    stall_n = 0; req_n = 0; addr_seen = '0; wdata_seen = '0; we_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      mem_ack = (ack_at != 0) && (k == ack_at);
      mem_rdata = rdata;
      #1;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          addr_seen = mem_addr; wdata_seen = mem_wdata; we_seen = mem_we;
        end
      end
      if (stall) stall_n++;
      else begin
        done = 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wait_bound: stall still high after 20 cycles");
    end
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
  endtask

  int          sn, rn;
  logic [31:0] as, ws;
  logic        wes;

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_op(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
    #2 reset = 1'b0;
    set_op(1'b0, 2'b11, 32'h40, 32'h0, 4'h1);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_wb", wb_data, 32'h0);
    chk("rst_err", {31'b0, mem_error}, 32'd0);
    step(); step();
    reset = 1'b1;

    // ALU pass-through
    set_op(1'b0, 2'b01, 32'h1234, 32'h0, 4'd5);
    #1 chk("pass_stall", {31'b0, stall}, 32'd0);
    step();
    chk("pass_wb", wb_data, 32'h1234);
    chk("pass_wbi", {30'b0, wbi_o}, 32'd1);
    chk("pass_reg", {28'b0, regaddr_o}, 32'd5);

    // Load, ack in 4th BUSY cycle (also the timeout cycle: ack wins)
    set_op(1'b0, 2'b11, 32'h40, 32'h0, 4'd3);
    run_mem(4, 32'hDEADBEEF, sn, rn, as, ws, wes);
    chk("ld_stall_cycles", sn, 32'd4);
    chk("ld_req_cycles", rn, 32'd4);
    chk("ld_addr", as, 32'h40);
    chk("ld_we", {31'b0, wes}, 32'd0);
    chk("ld_wb", wb_data, 32'hDEADBEEF);
    chk("ld_wbi", {30'b0, wbi_o}, 32'd3);
    chk("ld_err", {31'b0, mem_error}, 32'd0);

    // Store, immediate ack
    set_op(1'b1, 2'b00, 32'h80, 32'hA5A5A5A5, 4'd4);
    run_mem(1, 32'h0, sn, rn, as, ws, wes);
    chk("st_req_cycles", rn, 32'd1);
    chk("st_we", {31'b0, wes}, 32'd1);
    chk("st_wdata", ws, 32'hA5A5A5A5);
    chk("st_wbi", {30'b0, wbi_o}, 32'd0);
    chk("st_wb", wb_data, 32'h80);

    // Timeout
    set_op(1'b0, 2'b11, 32'h100, 32'h0, 4'd6);
    run_mem(0, 32'h0, sn, rn, as, ws, wes);
    chk("to_req_cycles", rn, 32'd4);
    chk("to_req_low", {31'b0, mem_req}, 32'd0);
    chk("to_err", {31'b0, mem_error}, 32'd1);
    chk("to_wbi", {30'b0, wbi_o}, 32'd0);
    chk("to_wb", wb_data, 32'h0);
    set_op(1'b0, 2'b01, 32'h9, 32'h0, 4'd2);
    step();
    chk("err_sticky", {31'b0, mem_error}, 32'd1);

    // Reset two cycles into BUSY
    set_op(1'b0, 2'b11, 32'h200, 32'h0, 4'd8);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rb_req", {31'b0, mem_req}, 32'd0);
    chk("rb_stall", {31'b0, stall}, 32'd0);
    chk("rb_addr", mem_addr, 32'h0);
    chk("rb_err", {31'b0, mem_error}, 32'd0);
    set_op(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
    step(); step();
    reset = 1'b1;

    // Ack in IDLE is ignored
    set_op(1'b0, 2'b01, 32'h77, 32'h0, 4'd9);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_wb", wb_data, 32'h77);
    chk("idle_ack_req", {31'b0, mem_req}, 32'd0);

    // Misaligned load
    set_op(1'b0, 2'b11, 32'h41, 32'h0, 4'd2);
    run_mem(0, 32'h0, sn, rn, as, ws, wes);
    chk("mis_stall", sn, 32'd0);
    chk("mis_req", rn, 32'd0);
    chk("mis_err", {31'b0, mem_error}, 32'd1);

    // Ack on the timeout cycle with error already set
    set_op(1'b0, 2'b10, 32'h44, 32'h0, 4'd1);
    run_mem(MW, 32'h11223344, sn, rn, as, ws, wes);
    chk("col_wb", wb_data, 32'h11223344);
    chk("col_wbi", {30'b0, wbi_o}, 32'd2);
    chk("col_err", {31'b0, mem_error}, 32'd1);

    // Back-to-back: store with load bit set, then a load
    set_op(1'b1, 2'b11, 32'h84, 32'h1, 4'd7);
    run_mem(2, 32'h0, sn, rn, as, ws, wes);
    chk("b2b_st_stall", sn, 32'd2);
    chk("b2b_st_wbi", {30'b0, wbi_o}, 32'd0);
    set_op(1'b0, 2'b11, 32'h88, 32'h0, 4'd10);
    run_mem(1, 32'hCAFEF00D, sn, rn, as, ws, wes);
    chk("b2b_ld_stall", sn, 32'd1);
    chk("b2b_ld_wb", wb_data, 32'hCAFEF00D);
    chk("b2b_ld_reg", {28'b0, regaddr_o}, 32'd10);

    set_op(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Parameters
REQ-001 SHALL provide MAX_WAIT, default 15, meaning the maximum BUSY cycles awaiting mem_ack before timeout (legal range 1..255).

Interface
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port alu_out  in  32  ALU result from the execute stage; memory byte address for loads and stores.
REQ-005 SHALL have port data_b  in  32  store data.
REQ-006 SHALL have port wbi  in  2  writeback control; bit0 = register write, bit1 = load (memory-to-register).
REQ-007 SHALL have port M  in  1  store request.
REQ-008 SHALL have port regaddr  in  4  destination register.
REQ-009 SHALL have port mem_rdata  in  32  read data, valid when mem_ack = 1.
REQ-010 SHALL have port mem_ack  in  1  one-cycle memory completion pulse.
REQ-011 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32) and mem_wdata (out, 32), all registered.
REQ-012 SHALL have port stall  out  1  combinational; holds the upstream stage and its outputs frozen.
REQ-013 SHALL have ports wb_data (out, 32), wbi_o (out, 2) and regaddr_o (out, 4), all registered, feeding writeback.
REQ-014 SHALL have port mem_error  out  1  sticky error flag.

Function
REQ-015 SHALL classify the input instruction as follows: mem-op = M | wbi[1]; store = M; load = wbi[1] & ~M.
REQ-016 SHALL treat M = 1 together with wbi[1] = 1 as a store and force wbi_o = 00 for that instruction.
REQ-017 SHALL implement a state machine with states IDLE and BUSY.
REQ-018 In IDLE, a non-mem-op SHALL produce wb_data <= alu_out, wbi_o <= wbi and regaddr_o <= regaddr at the next edge (1-cycle latency), with stall = 0.
REQ-019 In IDLE, an aligned mem-op (alu_out[1:0] = 00) SHALL assert stall = 1 and, at the next edge, set mem_req = 1, mem_addr = alu_out, mem_we = store, mem_wdata = data_b, move to BUSY and issue a bubble (wbi_o = 00).
REQ-020 In IDLE, a misaligned mem-op SHALL issue no request, set mem_error, issue a bubble and keep stall = 0, so the instruction retires in 1 cycle.
REQ-021 In BUSY, stall SHALL equal ~mem_ack, and mem_req, mem_addr, mem_we and mem_wdata SHALL be held stable.
REQ-022 In BUSY with mem_ack = 1, the next edge SHALL clear mem_req and mem_we and return to IDLE.
REQ-023 On that completion edge, a load SHALL produce wb_data = mem_rdata and a store SHALL produce wb_data = alu_out; wbi_o and regaddr_o SHALL take the held inputs, subject to REQ-016.
REQ-024 In BUSY, a wait counter SHALL count cycles without mem_ack; on reaching MAX_WAIT, stall SHALL go to 0 and the next edge SHALL clear mem_req, set mem_error, issue wbi_o = 00 and wb_data = 0, and return to IDLE.
REQ-025 When mem_ack coincides with the timeout cycle, the ack SHALL take priority and no error SHALL be raised.
REQ-026 mem_ack received in IDLE SHALL be ignored.
REQ-027 While stall = 1, wbi_o SHALL be 00 each cycle, so writeback sees only bubbles.
REQ-028 The counter SHALL be 8 bits, cleared on entry to BUSY, and never wrap.
REQ-029 Back-to-back mem-ops SHALL each take 1 stall cycle in IDLE plus BUSY cycles; no request overlap is permitted.
REQ-030 mem_error SHALL remain set until reset.

Reset
REQ-031 reset = 0 SHALL immediately force state IDLE, counter 0, and mem_req, mem_we, mem_addr, mem_wdata, wb_data, wbi_o, regaddr_o and mem_error all to 0.
REQ-032 stall SHALL be 0 while reset = 0.
REQ-033 Reset asserted during BUSY SHALL drop mem_req asynchronously, with no completion or error recorded.
REQ-034 After reset release, the first rising edge SHALL evaluate the inputs normally.

Verification
REQ-035 Bench SHALL cover ALU pass-through: wbi = 01, alu_out = 0x1234, regaddr = 5 -> next edge wb_data = 0x1234, wbi_o = 01, regaddr_o = 5, stall never 1.
REQ-036 Bench SHALL cover a load with 3-cycle ack: wbi = 11, alu_out = 0x40, ack 3 cycles after mem_req, mem_rdata = 0xDEADBEEF -> mem_addr = 0x40, mem_we = 0, stall high 4 cycles, wb_data = 0xDEADBEEF, wbi_o = 11.
REQ-037 Bench SHALL cover a store with immediate ack: M = 1, wbi = 00, alu_out = 0x80, data_b = 0xA5A5A5A5 -> mem_we = 1, mem_wdata = 0xA5A5A5A5, mem_req high exactly 1 cycle, wbi_o = 00.
REQ-038 Bench SHALL cover timeout: load with MAX_WAIT = 4 and no ack -> mem_req drops after 4 BUSY cycles, mem_error = 1 and sticky, wbi_o = 00.
REQ-039 Bench SHALL cover misalignment and ack-timeout collision: alu_out = 0x41 load -> no mem_req, mem_error = 1, stall = 0; ack on the MAX_WAIT cycle -> normal completion, mem_error unchanged.
REQ-040 Bench SHALL cover reset mid-BUSY: reset = 0 asserted 2 cycles into BUSY -> mem_req = 0 within the same cycle, all outputs 0, state IDLE after release.
